// File: rtl/decoder_scan_ctrl_if.sv
// Signal bundle between a scan requester and decoder_scan_ctrl.
// Control inputs are plain levels sampled on clk; every output is registered in the controller.
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         sel;
    logic               en;
    logic               busy;
    logic               wrap;
    logic [1:0]         state_dbg;

    modport master (
        output start, stop, mask, dwell,
        input  sel, en, busy, wrap, state_dbg
    );

    modport slave (
        input  start, stop, mask, dwell,
        output sel, en, busy, wrap, state_dbg
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan controller for a 2-to-4 enabled decoder: dwells on each
// enabled channel, with a one-cycle en-low blank between channel changes.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    decoder_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         sel_q;
    logic               en_q;
    logic               busy_q;
    logic               wrap_q;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;

    logic [1:0] first_sel;
    logic [1:0] nxt_sel;
    logic [1:0] idx;
    logic       nxt_wrap;

    // Offset 4 wraps back to sel itself, so a single-channel mask re-selects it.
    always_comb begin
        first_sel = 2'd0;
        nxt_sel   = sel_q;
        idx       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.mask[k]) first_sel = 2'(k);
        end
        for (int k = 4; k >= 1; k--) begin
            idx = sel_q + 2'(k);
            if (bus.mask[idx]) nxt_sel = idx;
        end
        nxt_wrap = (|bus.mask) && (nxt_sel <= sel_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= 2'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt     <= '0;
            dwell_q <= '0;
        end else if (bus.stop) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    en_q   <= 1'b0;
                    wrap_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start && (|bus.mask)) begin
                        state   <= ACTIVE;
                        sel_q   <= first_sel;
                        cnt     <= '0;
                        dwell_q <= bus.dwell;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // Compare before increment keeps cnt <= dwell_q, so it never overflows.
                    if (cnt == dwell_q) begin
                        state  <= BLANK;
                        en_q   <= 1'b0;
                        wrap_q <= nxt_wrap;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    wrap_q <= 1'b0;
                    if (!(|bus.mask)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state   <= ACTIVE;
                        sel_q   <= nxt_sel;
                        cnt     <= '0;
                        dwell_q <= bus.dwell;
                        en_q    <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                    wrap_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;
    assign bus.wrap      = wrap_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: inputs change #1 after the rising edge,
// outputs are checked at the same point, i.e. the value registered by that edge.
module tb_decoder_scan_ctrl;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    decoder_scan_ctrl_if #(.DWELL_W(8)) bus ();

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {sel, en, busy, wrap}
    function automatic logic [4:0] snap();
        return {bus.sel, bus.en, bus.busy, bus.wrap};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total_cnt++;
        if (snap() !== 5'b00_0_0_0) $display("FAIL reset_outputs got %b exp %b", snap(), 5'b00000);
        else pass_cnt++;
        total_cnt++;
        if (bus.state_dbg !== 2'd0) $display("FAIL reset_state got %0d exp 0", bus.state_dbg);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_sweep();
        logic [4:0] exp_q[$];
        logic [4:0] exp;
        int ch, ph;
        for (int c = 0; c < 17; c++) begin
            ch = (c / 4) % 4;
            ph = c % 4;
            exp_q.push_back({2'(ch), (ph < 3), 1'b1, (ph == 3 && ch == 3)});
        end
        bus.mask = 4'b1111;
        bus.dwell = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 17; c++) begin
            exp = exp_q.pop_front();
            total_cnt++;
            if (snap() !== exp) $display("FAIL sweep c=%0d got %b exp %b", c, snap(), exp);
            else pass_cnt++;
            // start while busy must not restart the scan
            bus.start = (c == 5);
            step();
        end
        bus.start = 1'b0;
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        total_cnt++;
        if (snap() !== 5'b00_0_0_0) $display("FAIL sweep_stop got %b exp %b", snap(), 5'b00000);
        else pass_cnt++;
    endtask

    task automatic test_sparse();
        logic [4:0] exp;
        bus.mask = 4'b1010;
        bus.dwell = 8'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp = {((c % 4) < 2) ? 2'd1 : 2'd3, (c % 2 == 0), 1'b1, (c % 4 == 3)};
            total_cnt++;
            if (snap() !== exp) $display("FAIL sparse c=%0d got %b exp %b", c, snap(), exp);
            else pass_cnt++;
            step();
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic test_single_dynamic();
        logic [4:0] exp;
        bus.mask = 4'b0100;
        bus.dwell = 8'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            exp = {2'd2, (c % 3 < 2), 1'b1, (c % 3 == 2)};
            total_cnt++;
            if (snap() !== exp) $display("FAIL single c=%0d got %b exp %b", c, snap(), exp);
            else pass_cnt++;
            step();
        end
        // first cycle of a fresh dwell: drop the whole mask
        bus.mask = 4'b0000;
        step();
        total_cnt++;
        if (snap() !== 5'b10_1_1_0) $display("FAIL dyn_dwell got %b exp %b", snap(), 5'b10110);
        else pass_cnt++;
        step();
        total_cnt++;
        if (snap() !== 5'b10_0_1_0) $display("FAIL dyn_blank got %b exp %b", snap(), 5'b10010);
        else pass_cnt++;
        step();
        total_cnt++;
        if (snap() !== 5'b10_0_0_0) $display("FAIL dyn_idle got %b exp %b", snap(), 5'b10000);
        else pass_cnt++;
    endtask

    task automatic test_stop();
        bus.mask = 4'b0110;
        bus.dwell = 8'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        total_cnt++;
        if (snap() !== 5'b01_1_1_0) $display("FAIL stop_pre got %b exp %b", snap(), 5'b01110);
        else pass_cnt++;
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        total_cnt++;
        if (snap() !== 5'b01_0_0_0) $display("FAIL stop_post got %b exp %b", snap(), 5'b01000);
        else pass_cnt++;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        step();
        total_cnt++;
        if (snap() !== 5'b01_0_0_0) $display("FAIL start_stop got %b exp %b", snap(), 5'b01000);
        else pass_cnt++;
        bus.stop = 1'b0;
        bus.mask = 4'b0000;
        step();
        total_cnt++;
        if (snap() !== 5'b01_0_0_0) $display("FAIL start_mask0_a got %b exp %b", snap(), 5'b01000);
        else pass_cnt++;
        step();
        total_cnt++;
        if (snap() !== 5'b01_0_0_0) $display("FAIL start_mask0_b got %b exp %b", snap(), 5'b01000);
        else pass_cnt++;
        bus.start = 1'b0;
    endtask

    task automatic test_dwell_max();
        int n;
        bus.mask = 4'b0001;
        bus.dwell = 8'd255;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (bus.en === 1'b1 && n < 300) begin
            n++;
            step();
        end
        total_cnt++;
        if (n !== 256) $display("FAIL dwell_max_len got %0d exp 256", n);
        else pass_cnt++;
        total_cnt++;
        if (snap() !== 5'b00_0_1_1) $display("FAIL dwell_max_blank got %b exp %b", snap(), 5'b00011);
        else pass_cnt++;
        step();
        total_cnt++;
        if (snap() !== 5'b00_1_1_0) $display("FAIL dwell_max_again got %b exp %b", snap(), 5'b00110);
        else pass_cnt++;
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        bus.mask = 4'b1111;
        bus.dwell = 8'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) step();
        total_cnt++;
        if (snap() !== 5'b01_1_1_0) $display("FAIL mid_pre got %b exp %b", snap(), 5'b01110);
        else pass_cnt++;
        rst_n = 1'b0;
        bus.start = 1'b1;
        step();
        total_cnt++;
        if (snap() !== 5'b00_0_0_0) $display("FAIL mid_rst1 got %b exp %b", snap(), 5'b00000);
        else pass_cnt++;
        step();
        total_cnt++;
        if (snap() !== 5'b00_0_0_0) $display("FAIL mid_rst2 got %b exp %b", snap(), 5'b00000);
        else pass_cnt++;
        rst_n = 1'b1;
        bus.start = 1'b0;
        step();
        total_cnt++;
        if (snap() !== 5'b00_0_0_0) $display("FAIL mid_after got %b exp %b", snap(), 5'b00000);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.mask = 4'b0000;
        bus.dwell = 8'd0;
        test_reset();
        test_full_sweep();
        test_sparse();
        test_single_dynamic();
        test_stop();
        test_dwell_max();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
